// File: rtl/serial_adder_core.sv
// -----------------------------------------------------------------------------
// serial_adder_core
//
// Bit-serial, LSB-first binary adder built around one registered carry
// flip-flop. Each accepted input bit produces a registered sum bit and carry.
// Bits framed by i_start are also packed into a WIDTH-bit word. The word is
// published on o_sum_word/o_carry_final with a one-cycle o_done pulse.
//
// Parameters:
//   WIDTH          operand word length in bits (2..64)
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active high
//   i_a, i_b       serial operand bits, LSB first
//   i_cin          carry-in for bit 0 of a word (used only with i_start=1)
//   i_start        current valid bit is bit 0 of a new word
//   i_valid_in     i_a/i_b/i_cin/i_start are meaningful this cycle
//   o_sum          registered sum bit of the last accepted bit
//   o_cout         registered carry of the last accepted bit
//   o_sum_word     packed result of the last completed word
//   o_carry_final  carry-out of the last completed word
//   o_done         one-cycle pulse: o_sum_word/o_carry_final just updated
//   o_busy         a word is in progress (bits 1..WIDTH-1 outstanding)
// -----------------------------------------------------------------------------
module serial_adder_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_a,
  input  logic             i_b,
  input  logic             i_cin,
  input  logic             i_start,
  input  logic             i_valid_in,
  output logic             o_sum,
  output logic             o_cout,
  output logic [WIDTH-1:0] o_sum_word,
  output logic             o_carry_final,
  output logic             o_done,
  output logic             o_busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;
  logic             r_carry;
  logic             r_sum;
  logic             r_cout;
  logic             r_done;
  logic             r_carry_final;
  logic [WIDTH-1:0] r_sum_word;
  // Holds the first WIDTH-1 sum bits of a word; the final bit is merged in
  // combinationally when the word completes.
  logic [WIDTH-2:0] r_shift;

  logic             w_c_in_eff;
  logic             w_sum_bit;
  logic             w_maj;
  logic             w_last_bit;
  logic             w_complete;
  logic [WIDTH-1:0] w_shift_next;

  // ---------------------------------------------------------------------------
  // Full-adder cell. A start bit reseeds the chain from i_cin instead of the
  // carry left over from whatever was accepted before.
  // ---------------------------------------------------------------------------
  assign w_c_in_eff = i_start ? i_cin : r_carry;
  assign w_sum_bit  = i_a ^ i_b ^ w_c_in_eff;
  assign w_maj      = (i_a & i_b) | (i_a & w_c_in_eff) | (i_b & w_c_in_eff);

  // The WIDTH-th bit completes the word only if it is not itself a restart.
  assign w_last_bit = (r_state == S_BUSY) && !i_start && (r_count == LAST_IDX);
  assign w_complete = i_valid_in && w_last_bit;

  // Right shift: newest bit enters at the MSB so bit 0 lands at index 0.
  assign w_shift_next = {w_sum_bit, r_shift};

  // ---------------------------------------------------------------------------
  // Word framing FSM: next-state and bit counter
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    w_count_next = r_count;

    if (i_valid_in) begin
      if (i_start) begin
        w_state_next = S_BUSY;
        w_count_next = CW'(1);
      end else if (r_state == S_BUSY) begin
        if (w_last_bit) begin
          w_state_next = S_IDLE;
          w_count_next = '0;
        end else begin
          w_count_next = r_count + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers. With valid_in low everything holds, and done drops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum         <= 1'b0;
      r_cout        <= 1'b0;
      r_carry       <= 1'b0;
      r_shift       <= '0;
      r_sum_word    <= '0;
      r_carry_final <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= w_complete;
      if (i_valid_in) begin
        r_sum   <= w_sum_bit;
        r_cout  <= w_maj;
        r_carry <= w_maj;
        r_shift <= w_shift_next[WIDTH-1:1];
      end
      if (w_complete) begin
        r_sum_word    <= w_shift_next;
        r_carry_final <= w_maj;
      end
    end
  end

  assign o_sum         = r_sum;
  assign o_cout        = r_cout;
  assign o_sum_word    = r_sum_word;
  assign o_carry_final = r_carry_final;
  assign o_done        = r_done;
  assign o_busy        = (r_state == S_BUSY);

endmodule

// File: tb/tb_serial_adder_core.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_core
//
// Scoreboard bench for serial_adder_core. The driver computes expected
// responses from plain integer arithmetic on whole operand words and queues
// them; an independent monitor compares DUT outputs as they appear.
// -----------------------------------------------------------------------------
module tb_serial_adder_core;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             a, b, cin, start, valid_in;
  logic             sum, cout, carry_final, done, busy;
  logic [WIDTH-1:0] sum_word;

  serial_adder_core #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_a           (a),
    .i_b           (b),
    .i_cin         (cin),
    .i_start       (start),
    .i_valid_in    (valid_in),
    .o_sum         (sum),
    .o_cout        (cout),
    .o_sum_word    (sum_word),
    .o_carry_final (carry_final),
    .o_done        (done),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic sum;
    logic cout;
    logic done;
  } bit_exp_t;

  typedef struct packed {
    logic             carry;
    logic [WIDTH-1:0] word;
  } word_exp_t;

  bit_exp_t  bit_q[$];
  word_exp_t word_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: running carry for the serial stream, plus the operand
  // words of the framed word in progress; completed words are summed as
  // integers.
  // ---------------------------------------------------------------------------
  logic             m_carry = 1'b0;
  bit               m_busy  = 1'b0;
  int               m_idx   = 0;
  logic [WIDTH-1:0] m_a, m_b;
  logic             m_cin;

  task automatic model_reset();
    m_carry = 1'b0;
    m_busy  = 1'b0;
    m_idx   = 0;
  endtask

  task automatic send_bit(input logic ia, input logic ib, input logic icin, input logic istart);
    logic       c;
    logic [1:0] t;
    logic       fin;
    logic [WIDTH:0] full;
    @(negedge clk);
    a = ia; b = ib; cin = icin; start = istart; valid_in = 1'b1;
    c = istart ? icin : m_carry;
    t = {1'b0, ia} + {1'b0, ib} + {1'b0, c};
    m_carry = t[1];
    fin = 1'b0;
    if (istart) begin
      m_busy = 1'b1;
      m_idx  = 1;
      m_a    = '0;
      m_b    = '0;
      m_a[0] = ia;
      m_b[0] = ib;
      m_cin  = icin;
    end else if (m_busy) begin
      m_a[m_idx] = ia;
      m_b[m_idx] = ib;
      m_idx++;
      if (m_idx == WIDTH) begin
        fin    = 1'b1;
        m_busy = 1'b0;
        full   = {1'b0, m_a} + {1'b0, m_b} + {{WIDTH{1'b0}}, m_cin};
        word_q.push_back('{carry: full[WIDTH], word: full[WIDTH-1:0]});
      end
    end
    bit_q.push_back('{sum: t[0], cout: t[1], done: fin});
    @(posedge clk);
  endtask

  // Stall cycles with garbage on the data/start lines, which must be ignored.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      valid_in = 1'b0;
      a        = 1'($urandom);
      b        = 1'($urandom);
      cin      = 1'($urandom);
      start    = 1'($urandom);
      @(posedge clk);
    end
  endtask

  task automatic run_word(input logic [WIDTH-1:0] wa, input logic [WIDTH-1:0] wb,
                          input logic wcin, input logic [WIDTH-1:0] stall_after);
    for (int i = 0; i < WIDTH; i++) begin
      send_bit(wa[i], wb[i], wcin, (i == 0));
      if (stall_after[i] && i != WIDTH - 1) idle(2);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: one accepted bit -> one queued response; stalls freeze outputs.
  // ---------------------------------------------------------------------------
  logic      mon_v, mon_r;
  logic      last_sum = 1'b0, last_cout = 1'b0;
  bit_exp_t  mon_e;
  word_exp_t mon_w;

  always @(posedge clk) begin
    mon_v = valid_in;
    mon_r = rst;
    #1;
    if (mon_r) begin
      last_sum  = 1'b0;
      last_cout = 1'b0;
    end else begin
      if (mon_v) begin
        if (bit_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bit_response actual=unexpected required=none @%0t", $time);
        end else begin
          mon_e = bit_q.pop_front();
          check("serial_sum",  64'(sum),  64'(mon_e.sum));
          check("serial_cout", 64'(cout), 64'(mon_e.cout));
          check("done_flag",   64'(done), 64'(mon_e.done));
        end
        last_sum  = sum;
        last_cout = cout;
      end else begin
        check("stall_sum",  64'(sum),  64'(last_sum));
        check("stall_cout", 64'(cout), 64'(last_cout));
        check("stall_done", 64'(done), 64'd0);
      end
      if (done) begin
        if (word_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_response actual=done required=no_done @%0t", $time);
        end else begin
          mon_w = word_q.pop_front();
          check("sum_word",    64'(sum_word),    64'(mon_w.word));
          check("carry_final", 64'(carry_final), 64'(mon_w.carry));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    a = 1'b0; b = 1'b0; cin = 1'b0; start = 1'b0; valid_in = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_sum",         64'(sum),         64'd0);
    check("rst_cout",        64'(cout),        64'd0);
    check("rst_sum_word",    64'(sum_word),    64'd0);
    check("rst_carry_final", 64'(carry_final), 64'd0);
    check("rst_done",        64'(done),        64'd0);
    check("rst_busy",        64'(busy),        64'd0);
    rst = 1'b0;

    // Reset mid-word: three bits of 0xFF+0xFF, then asynchronous reset.
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1, 1'b0, (i == 0));
    @(negedge clk);
    valid_in = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_sum",  64'(sum),  64'd0);
    check("midrst_cout", 64'(cout), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Directed words with known answers.
    run_word(8'h5A, 8'h33, 1'b0, 8'h00);
    #1;
    check("w5A33_done",  64'(done),        64'd1);
    check("w5A33_word",  64'(sum_word),    64'h8D);
    check("w5A33_carry", 64'(carry_final), 64'd0);

    run_word(8'hFF, 8'h01, 1'b0, 8'h00);
    #1;
    check("wFF01_word",  64'(sum_word),    64'h00);
    check("wFF01_carry", 64'(carry_final), 64'd1);

    run_word(8'h00, 8'h00, 1'b1, 8'h00);
    #1;
    check("w0000c_word",  64'(sum_word),    64'h01);
    check("w0000c_carry", 64'(carry_final), 64'd0);

    run_word(8'h5A, 8'h33, 1'b0, 8'b0010_0100);
    #1;
    check("stall_word_done", 64'(done),     64'd1);
    check("stall_word",      64'(sum_word), 64'h8D);

    // Restart at bit 4 of 0xFF+0xFF, then a full 0x0F+0x01.
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1, 1'b0, (i == 0));
    run_word(8'h0F, 8'h01, 1'b0, 8'h00);
    #1;
    check("restart_word",  64'(sum_word),    64'h10);
    check("restart_carry", 64'(carry_final), 64'd0);

    // Start landing on the would-be last bit: restart wins, no done.
    for (int i = 0; i < WIDTH - 1; i++) send_bit(1'b1, 1'b0, 1'b1, (i == 0));
    run_word(8'h12, 8'h34, 1'b0, 8'h00);
    #1;
    check("lastrestart_word", 64'(sum_word), 64'h46);

    // Free-running bits outside a word leave the word outputs alone.
    for (int i = 0; i < 3; i++) send_bit(1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    #1;
    check("free_word", 64'(sum_word), 64'h46);
    check("free_busy", 64'(busy),     64'd0);

    // Randomized traffic: stalls, restarts, ignored cin, back-to-back words.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(3) == 0) idle(1);
      else send_bit(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(9) == 0));
    end

    idle(2);
    #1;
    check("bit_q_drained",  64'(bit_q.size()),  64'd0);
    check("word_q_drained", 64'(word_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
